// File: rtl/ifu8_pkg.sv
// ============================================================================
// Module   : ifu8_pkg
// Brief    : Shared types and constants for the ifu8 instruction fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifu8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b10
  } state_t;

  localparam logic [15:0] EMPTY_INST = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/ifq.sv
// ============================================================================
// Module   : ifq
// Brief    : Synchronous prefetch FIFO; flush dominates push and pop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifq #(
  parameter int DEPTH = 2,
  parameter int W     = 24,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop of an empty queue and push into a full one (without a pop) are dropped.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) r_mem[r_wr] <= din;
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifu8.sv
// ============================================================================
// Module   : ifu8
// Brief    : Instruction fetch unit: req/ack memory handshake feeding a
//            prefetch queue, with redirect, flush and in-flight discard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu8
  import ifu8_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  input  logic            take,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            redir,
  input  logic [PC_W-1:0] redir_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = PC_W + 16;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [PC_W-1:0] r_addr, w_addr_nxt;
  logic [CW-1:0]   w_count;
  logic [QW-1:0]   w_head;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic            w_room_after;

  assign w_valid = (w_count != '0);
  assign w_pop   = take && !redir;
  assign w_room  = (w_count < CW'(DEPTH));
  // Occupancy after this cycle's push: a real pop cancels it out.
  assign w_room_after = (take && w_valid) ? 1'b1 : (w_count < CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (redir) begin
          w_pc_nxt = redir_pc;
        end else if (w_room) begin
          w_state_nxt = WAIT;
          w_addr_nxt  = r_pc;
          w_pc_nxt    = r_pc + 1'b1;
        end
      end
      WAIT: begin
        if (redir) begin
          w_pc_nxt    = redir_pc;
          w_state_nxt = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          w_push = 1'b1;
          if (w_room_after) begin
            w_addr_nxt = r_pc;
            w_pc_nxt   = r_pc + 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (redir)   w_pc_nxt    = redir_pc;
        if (mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ifq #(
    .DEPTH (DEPTH),
    .W     (QW)
  ) u_ifq (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redir),
    .din   ({r_addr, mem_rdata}),
    .head  (w_head),
    .count (w_count)
  );

  assign mem_req    = (r_state != IDLE);
  assign mem_addr   = r_addr;
  assign inst_valid = w_valid;
  assign inst       = w_valid ? w_head[15:0] : EMPTY_INST;
  assign inst_pc    = w_valid ? w_head[QW-1:16] : '0;

endmodule

`default_nettype wire

// File: doc/ifu8.md
# ifu8

Instruction fetch unit for the 8-bit core. Initiates reads from instruction memory over a req/ack handshake and buffers returned 16-bit words in a small prefetch queue. Presents the head instruction to the core, which consumes it with a one-cycle take pulse (the core's IR load enable in its fetch state). Supports PC redirect with queue flush and discard of an in-flight response.

## Interface
- PC_W, 8, instruction address width; addresses wrap modulo 2^PC_W
- DEPTH, 2, prefetch queue entries (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_req  out  1  read request; held high until mem_ack
- mem_addr  out  PC_W  address of outstanding request; stable while mem_req=1
- mem_ack  in  1  one-cycle response strobe; mem_rdata valid same cycle
- mem_rdata  in  16  instruction word
- take  in  1  core consumes head instruction this cycle
- inst  out  16  head instruction; 16'h0000 when queue empty
- inst_pc  out  PC_W  address of head instruction; 0 when empty
- inst_valid  out  1  queue non-empty
- redir  in  1  redirect fetch stream
- redir_pc  in  PC_W  new fetch address

## Operation
- Registers: pc (next address to request), addr_q (outstanding address), state, queue of {addr, word}, count (0..DEPTH).
- States: IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE: if count < DEPTH → WAIT, addr_q ← pc, pc ← pc+1. Else stay.
- WAIT, mem_ack: push {addr_q, mem_rdata}. If resulting count < DEPTH → stay WAIT, addr_q ← pc, pc ← pc+1 (back-to-back); else → IDLE.
- DROP, mem_ack: data ignored, → IDLE.
- mem_req = (state ≠ IDLE); mem_addr = addr_q.
- Push only on WAIT ack; only pops occur during WAIT, so a push always has room.
- take with inst_valid=1: pop head. take with queue empty: ignored, count does not underflow.
- take and push same cycle: both occur, count unchanged.
- redir (highest priority): queue flushed (count ← 0), take ignored, pc ← redir_pc. IDLE → IDLE (issue next cycle). WAIT without ack → DROP. WAIT with ack → IDLE, data dropped. DROP with ack → IDLE; DROP without ack → stays DROP.
- Never more than one outstanding request; mem_addr must not change while mem_req=1, even on redir.
- Address arithmetic: pc+1 truncated to PC_W bits; 2^PC_W−1 wraps to 0.

## Timing
- Reset: state=IDLE, pc=0, addr_q=0, count=0; mem_req=0, mem_addr=0, inst=0, inst_pc=0, inst_valid=0. rst mid-transaction abandons the outstanding request; a late mem_ack after reset is ignored (state IDLE).
- First mem_req high the cycle after rst deasserts, mem_addr=0.
- Ack at edge t → inst_valid/inst updated after edge t (visible cycle t+1).
- With single-cycle-ack memory and a consumer taking every cycle, one instruction is delivered per cycle (mem_req stays high).
- redir at edge t → earliest new request mem_addr=redir_pc in cycle t+1 (from IDLE) or one cycle after the pending ack completes (from WAIT/DROP).
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.

## Structure
- Package ifu8_pkg: state encoding (IDLE=2'b00, WAIT=2'b01, DROP=2'b10), EMPTY_INST=16'h0000.
- Sub-module ifq: synchronous FIFO, parameters DEPTH and data width PC_W+16, ports push/pop/flush/count, head output; flush dominates push and pop.
- ifu8 holds pc, addr_q, state and the handshake logic only.

## Test plan
- Reset release, memory acks every cycle with word=addr+16'h1000, take every cycle → mem_addr 0,1,2…; inst 16'h1000,16'h1001… with inst_pc 0,1,2…, one per cycle.
- No take, acks immediate → exactly DEPTH(2) pushes, then mem_req=0, count=2; one take → one new request issued, mem_addr=2.
- redir to 8'h40 while WAIT on addr 5 and ack arrives 3 cycles later with 16'hDEAD → 16'hDEAD never appears, inst_valid=0 until word from 8'h40, mem_addr held at 5 during DROP.
- pc at 8'hFF, free-running → requests 8'hFF then 8'h00; inst_pc wraps accordingly.
- take with queue empty for 3 cycles, then ack → count never negative, first pushed word appears intact; simultaneous take+ack with count=1 keeps count=1.
- rst asserted while WAIT, stray mem_ack next cycle → no push, outputs remain at reset values, fetch restarts at 0.
